// File: rtl/commit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// commit_ctrl_pkg
//   Shared definitions for the dual-slot commit controller:
//     - FSM state encodings (RUN / FLUSHWAIT / IDLE)
//     - commit event kinds produced by the event selector
//     - 7-bit exception cause codes and parameter defaults
//     - slot_event(): per-slot event classification in priority order
// -----------------------------------------------------------------------------
package commit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSHWAIT = 2'd1,
        ST_IDLE      = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_INT  = 3'd1,
        EV_EXCP = 3'd2,
        EV_ERTN = 3'd3,
        EV_IDLE = 3'd4
    } event_e;

    // Exception cause codes (ESTAT.Ecode)
    localparam logic [6:0] ECODE_INT  = 7'h00;
    localparam logic [6:0] ECODE_PIL  = 7'h01;
    localparam logic [6:0] ECODE_PIS  = 7'h02;
    localparam logic [6:0] ECODE_PIF  = 7'h03;
    localparam logic [6:0] ECODE_PME  = 7'h04;
    localparam logic [6:0] ECODE_PPI  = 7'h07;
    localparam logic [6:0] ECODE_ADE  = 7'h08;
    localparam logic [6:0] ECODE_ALE  = 7'h09;
    localparam logic [6:0] ECODE_SYS  = 7'h0B;
    localparam logic [6:0] ECODE_BRK  = 7'h0C;
    localparam logic [6:0] ECODE_INE  = 7'h0D;
    localparam logic [6:0] ECODE_IPE  = 7'h0E;
    localparam logic [6:0] ECODE_FPD  = 7'h0F;
    localparam logic [6:0] ECODE_TLBR = 7'h3F;

    localparam logic [6:0]  INT_CAUSE_DEFAULT = ECODE_INT;
    localparam logic [31:0] PC_INC_DEFAULT    = 32'd4;

    // Classify one slot. An invalid slot never carries an event; the
    // interrupt is attached to the oldest valid instruction it meets.
    function automatic event_e slot_event(
        input logic valid,
        input logic int_ok,
        input logic excp,
        input logic ertn,
        input logic idle
    );
        event_e ev;
        ev = EV_NONE;
        if (valid) begin
            if (int_ok)    ev = EV_INT;
            else if (excp) ev = EV_EXCP;
            else if (ertn) ev = EV_ERTN;
            else if (idle) ev = EV_IDLE;
        end
        return ev;
    endfunction

endpackage

// File: rtl/commit_ctrl_event_sel.sv
// -----------------------------------------------------------------------------
// commit_event_sel
//   Combinational event picker for the two commit slots. Slot 0 is older and
//   is examined first; the first slot carrying an event wins.
//   Ports:
//     valid[1:0]      per-slot valid (already bubble-masked by the caller)
//     int_ok          interrupt pending and globally enabled
//     excp/ertn/idle  per-slot event flags
//     ev_slot         index of the winning slot (0 when ev_type is EV_NONE)
//     ev_type         kind of event taken
//     kill_mask[1:0]  slots whose architectural writes must be suppressed
// -----------------------------------------------------------------------------
module commit_event_sel
    import commit_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       int_ok,
    input  logic [1:0] excp,
    input  logic [1:0] ertn,
    input  logic [1:0] idle,
    output logic       ev_slot,
    output event_e     ev_type,
    output logic [1:0] kill_mask
);

    event_e ev0;
    event_e ev1;

    always_comb begin
        ev0       = slot_event(valid[0], int_ok, excp[0], ertn[0], idle[0]);
        ev1       = slot_event(valid[1], int_ok, excp[1], ertn[1], idle[1]);
        ev_slot   = 1'b0;
        ev_type   = EV_NONE;
        kill_mask = 2'b00;

        if (ev0 != EV_NONE) begin
            ev_slot = 1'b0;
            ev_type = ev0;
        end else if (ev1 != EV_NONE) begin
            ev_slot = 1'b1;
            ev_type = ev1;
        end

        // Traps squash the faulting slot itself; ertn/idle complete and only
        // squash what is younger than them.
        case (ev_type)
            EV_INT, EV_EXCP: kill_mask = ev_slot ? 2'b10 : 2'b11;
            EV_ERTN, EV_IDLE: kill_mask = ev_slot ? 2'b00 : 2'b10;
            default:          kill_mask = 2'b00;
        endcase
    end

endmodule

// File: rtl/commit_ctrl.sv
// -----------------------------------------------------------------------------
// commit_ctrl
//   Dual-slot commit controller placed right after the write-back register.
//   Decides which slots retire, converts interrupt/exception/ertn/idle into a
//   single flush + redirect with the matching CSR update pulse, and gates the
//   register-file / CSR / LLbit writes of everything younger than a trap.
//   All outputs are registered: one cycle from inputs to outputs.
//
//   Valid/ready: there is no back-pressure. commit_valid qualifies a slot in
//   the cycle it is presented; pause_mem=1 turns the cycle into a bubble.
//
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     commit_valid[1:0]          per-slot valid
//     excp_valid[1:0]            per-slot exception flag
//     excp_cause1/2, commit_pc1/2, commit_addr1/2   per-slot trap data
//     commit_ertn/commit_idle    per-slot ertn / idle flags
//     reg_we_in/csr_we_in/llbit_in   per-slot write enables to be gated
//     int_pending, crmd_ie       interrupt request and global enable
//     csr_eentry, csr_era        trap entry / return addresses
//     pause_mem                  memory stall (inputs are a bubble)
//     reg_we_out/csr_we_out/llbit_out   gated enables
//     flush, redirect_pc         flush pulse and fetch target
//     excp_we, era_out, cause_out, badv_out   trap CSR update pulse + data
//     ertn_we                    CRMD restore pulse
//     idle_stall                 front-end hold while idling
// -----------------------------------------------------------------------------
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter logic [6:0]  INT_CAUSE = INT_CAUSE_DEFAULT,
    parameter logic [31:0] PC_INC    = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  commit_valid,
    input  logic [1:0]  excp_valid,
    input  logic [6:0]  excp_cause1,
    input  logic [6:0]  excp_cause2,
    input  logic [31:0] commit_pc1,
    input  logic [31:0] commit_pc2,
    input  logic [31:0] commit_addr1,
    input  logic [31:0] commit_addr2,
    input  logic [1:0]  commit_ertn,
    input  logic [1:0]  commit_idle,
    input  logic [1:0]  reg_we_in,
    input  logic [1:0]  csr_we_in,
    input  logic [1:0]  llbit_in,
    input  logic        int_pending,
    input  logic        crmd_ie,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        pause_mem,
    output logic [1:0]  reg_we_out,
    output logic [1:0]  csr_we_out,
    output logic [1:0]  llbit_out,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        excp_we,
    output logic [31:0] era_out,
    output logic [6:0]  cause_out,
    output logic [31:0] badv_out,
    output logic        ertn_we,
    output logic        idle_stall
);

    // FSM state, kept as a named signal for observation
    state_e      state_q;
    state_e      state_d;
    logic [31:0] idle_pc_q;
    logic [31:0] idle_pc_d;

    logic [1:0]  valid;
    logic        int_ok;
    logic        ev_slot;
    event_e      ev_type;
    logic [1:0]  kill_mask;
    logic [31:0] ev_pc;
    logic [31:0] ev_addr;
    logic [6:0]  ev_cause;

    logic [1:0]  reg_we_d;
    logic [1:0]  csr_we_d;
    logic [1:0]  llbit_d;
    logic        flush_d;
    logic [31:0] redirect_d;
    logic        excp_we_d;
    logic [31:0] era_d;
    logic [6:0]  cause_d;
    logic [31:0] badv_d;
    logic        ertn_we_d;
    logic        idle_stall_d;

    // A stalled cycle is a bubble: nothing in it can retire or trap.
    assign valid  = commit_valid & ~{2{pause_mem}};
    assign int_ok = int_pending & crmd_ie;

    commit_event_sel u_event_sel (
        .valid     (valid),
        .int_ok    (int_ok),
        .excp      (excp_valid),
        .ertn      (commit_ertn),
        .idle      (commit_idle),
        .ev_slot   (ev_slot),
        .ev_type   (ev_type),
        .kill_mask (kill_mask)
    );

    assign ev_pc    = ev_slot ? commit_pc2   : commit_pc1;
    assign ev_addr  = ev_slot ? commit_addr2 : commit_addr1;
    assign ev_cause = ev_slot ? excp_cause2  : excp_cause1;

    always_comb begin
        state_d      = state_q;
        idle_pc_d    = idle_pc_q;
        reg_we_d     = 2'b00;
        csr_we_d     = 2'b00;
        llbit_d      = 2'b00;
        flush_d      = 1'b0;
        redirect_d   = 32'd0;
        excp_we_d    = 1'b0;
        era_d        = 32'd0;
        cause_d      = 7'd0;
        badv_d       = 32'd0;
        ertn_we_d    = 1'b0;
        idle_stall_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                reg_we_d = reg_we_in & valid & ~kill_mask;
                csr_we_d = csr_we_in & valid & ~kill_mask;
                llbit_d  = llbit_in  & valid & ~kill_mask;
                case (ev_type)
                    EV_INT: begin
                        excp_we_d  = 1'b1;
                        era_d      = ev_pc;
                        cause_d    = INT_CAUSE;
                        flush_d    = 1'b1;
                        redirect_d = csr_eentry;
                        state_d    = ST_FLUSHWAIT;
                    end
                    EV_EXCP: begin
                        excp_we_d  = 1'b1;
                        era_d      = ev_pc;
                        cause_d    = ev_cause;
                        badv_d     = ev_addr;
                        flush_d    = 1'b1;
                        redirect_d = csr_eentry;
                        state_d    = ST_FLUSHWAIT;
                    end
                    EV_ERTN: begin
                        ertn_we_d  = 1'b1;
                        flush_d    = 1'b1;
                        redirect_d = csr_era;
                        state_d    = ST_FLUSHWAIT;
                    end
                    EV_IDLE: begin
                        idle_stall_d = 1'b1;
                        flush_d      = 1'b1;
                        redirect_d   = ev_pc + PC_INC;
                        idle_pc_d    = ev_pc;
                        state_d      = ST_IDLE;
                    end
                    default: ;
                endcase
            end

            // Drops the bundle already in flight behind the flushing one.
            // A stalled cycle is not that bundle, so the wait is held.
            ST_FLUSHWAIT: begin
                if (!pause_mem) state_d = ST_RUN;
            end

            // Wake-up does not need a committing instruction, so it is taken
            // even through a memory stall. Return point is after the idle.
            ST_IDLE: begin
                idle_stall_d = 1'b1;
                if (int_ok) begin
                    idle_stall_d = 1'b0;
                    excp_we_d    = 1'b1;
                    era_d        = idle_pc_q + PC_INC;
                    cause_d      = INT_CAUSE;
                    flush_d      = 1'b1;
                    redirect_d   = csr_eentry;
                    state_d      = ST_FLUSHWAIT;
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            idle_pc_q   <= 32'd0;
            reg_we_out  <= 2'b00;
            csr_we_out  <= 2'b00;
            llbit_out   <= 2'b00;
            flush       <= 1'b0;
            redirect_pc <= 32'd0;
            excp_we     <= 1'b0;
            era_out     <= 32'd0;
            cause_out   <= 7'd0;
            badv_out    <= 32'd0;
            ertn_we     <= 1'b0;
            idle_stall  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_pc_q   <= idle_pc_d;
            reg_we_out  <= reg_we_d;
            csr_we_out  <= csr_we_d;
            llbit_out   <= llbit_d;
            flush       <= flush_d;
            redirect_pc <= redirect_d;
            excp_we     <= excp_we_d;
            era_out     <= era_d;
            cause_out   <= cause_d;
            badv_out    <= badv_d;
            ertn_we     <= ertn_we_d;
            idle_stall  <= idle_stall_d;
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_commit_ctrl
//   Self-checking bench for commit_ctrl. Each scenario task drives one input
//   bundle per cycle, pushes the hand-derived expected output vector onto
//   exp_q, and after the following clock edge pops and compares it.
// -----------------------------------------------------------------------------
module tb_commit_ctrl;
    import commit_ctrl_pkg::*;

    localparam int W = 113;
    typedef logic [W-1:0] vec_t;

    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_0200;
    localparam logic [31:0] PC1    = 32'h1C00_0000;
    localparam logic [31:0] PC2    = 32'h1C00_0004;
    localparam logic [6:0]  ICAUSE = 7'h00;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  commit_valid, excp_valid, commit_ertn, commit_idle;
    logic [6:0]  excp_cause1, excp_cause2;
    logic [31:0] commit_pc1, commit_pc2, commit_addr1, commit_addr2;
    logic [1:0]  reg_we_in, csr_we_in, llbit_in;
    logic        int_pending, crmd_ie, pause_mem;
    logic [31:0] csr_eentry, csr_era;
    logic [1:0]  reg_we_out, csr_we_out, llbit_out;
    logic        flush, excp_we, ertn_we, idle_stall;
    logic [31:0] redirect_pc, era_out, badv_out;
    logic [6:0]  cause_out;

    commit_ctrl dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .excp_valid(excp_valid),
        .excp_cause1(excp_cause1), .excp_cause2(excp_cause2),
        .commit_pc1(commit_pc1), .commit_pc2(commit_pc2),
        .commit_addr1(commit_addr1), .commit_addr2(commit_addr2),
        .commit_ertn(commit_ertn), .commit_idle(commit_idle),
        .reg_we_in(reg_we_in), .csr_we_in(csr_we_in), .llbit_in(llbit_in),
        .int_pending(int_pending), .crmd_ie(crmd_ie),
        .csr_eentry(csr_eentry), .csr_era(csr_era), .pause_mem(pause_mem),
        .reg_we_out(reg_we_out), .csr_we_out(csr_we_out), .llbit_out(llbit_out),
        .flush(flush), .redirect_pc(redirect_pc), .excp_we(excp_we),
        .era_out(era_out), .cause_out(cause_out), .badv_out(badv_out),
        .ertn_we(ertn_we), .idle_stall(idle_stall)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    vec_t want;
    vec_t act;
    int   n_checks = 0;
    int   n_fail   = 0;

    assign act = {reg_we_out, csr_we_out, llbit_out, flush, redirect_pc, excp_we,
                  era_out, cause_out, badv_out, ertn_we, idle_stall};

    function automatic vec_t pk(input logic [1:0] rw, input logic [1:0] cw,
                                input logic [1:0] lb, input logic fl,
                                input logic [31:0] rp, input logic ew,
                                input logic [31:0] era, input logic [6:0] cs,
                                input logic [31:0] bv, input logic tw,
                                input logic is);
        return {rw, cw, lb, fl, rp, ew, era, cs, bv, tw, is};
    endfunction

    function automatic vec_t pass(input logic [1:0] rw, input logic [1:0] cw,
                                  input logic [1:0] lb);
        return pk(rw, cw, lb, 1'b0, 32'd0, 1'b0, 32'd0, 7'd0, 32'd0, 1'b0, 1'b0);
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        commit_valid = 2'b00; excp_valid = 2'b00;
        commit_ertn  = 2'b00; commit_idle = 2'b00;
        excp_cause1  = 7'd0;  excp_cause2 = 7'd0;
        commit_pc1   = PC1;   commit_pc2  = PC2;
        commit_addr1 = 32'd0; commit_addr2 = 32'd0;
        reg_we_in    = 2'b00; csr_we_in = 2'b00; llbit_in = 2'b00;
        int_pending  = 1'b0;  crmd_ie = 1'b0; pause_mem = 1'b0;
        csr_eentry   = EENTRY; csr_era = ERA;
    endtask

    task automatic bundle(input logic [1:0] v, input logic [1:0] rw);
        clear_in();
        commit_valid = v;
        reg_we_in    = rw;
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        bundle(2'b11, 2'b11);
        csr_we_in = 2'b11; excp_valid = 2'b01;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('0);
            tick(); want = exp_q.pop_front(); n_checks++;
            if (act !== want) begin n_fail++; $display("FAIL reset act=%h exp=%h", act, want); end
        end
        rst = 1'b0;
        clear_in();
        tick();
    endtask

    task automatic test_pass_through();
        logic [1:0] v, rw, cw, lb;
        bundle(2'b11, 2'b11); csr_we_in = 2'b01; llbit_in = 2'b10;
        exp_q.push_back(pass(2'b11, 2'b01, 2'b10));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL pass_both act=%h exp=%h", act, want); end
        for (int i = 0; i < 6; i++) begin
            v  = 2'($urandom_range(0, 3));
            rw = 2'($urandom_range(0, 3));
            cw = 2'($urandom_range(0, 3));
            lb = 2'($urandom_range(0, 3));
            bundle(v, rw); csr_we_in = cw; llbit_in = lb;
            exp_q.push_back(pass(rw & v, cw & v, lb & v));
            tick(); want = exp_q.pop_front(); n_checks++;
            if (act !== want) begin n_fail++; $display("FAIL pass_rand act=%h exp=%h", act, want); end
        end
    endtask

    task automatic test_excp_slot0();
        bundle(2'b11, 2'b11); excp_valid = 2'b01; excp_cause1 = 7'h0B;
        commit_addr1 = 32'h1234; commit_ertn = 2'b10;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, EENTRY, 1'b1, PC1, 7'h0B,
                           32'h1234, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL excp_slot0 act=%h exp=%h", act, want); end
        bundle(2'b11, 2'b11); excp_valid = 2'b01;
        exp_q.push_back('0);
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL excp_flushwait act=%h exp=%h", act, want); end
        bundle(2'b11, 2'b11);
        exp_q.push_back(pass(2'b11, 2'b00, 2'b00));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL excp_resume act=%h exp=%h", act, want); end
    endtask

    task automatic test_excp_slot1();
        bundle(2'b11, 2'b11); excp_valid = 2'b10; excp_cause2 = 7'h0D;
        commit_addr2 = 32'h55; llbit_in = 2'b11;
        exp_q.push_back(pk(2'b01, 2'b00, 2'b01, 1'b1, EENTRY, 1'b1, PC2, 7'h0D,
                           32'h55, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL excp_slot1 act=%h exp=%h", act, want); end
        clear_in();
        tick();
        // slot 0 empty, slot 1 valid: slot 1 is evaluated on its own
        bundle(2'b10, 2'b11); excp_valid = 2'b11; excp_cause1 = 7'h01;
        excp_cause2 = 7'h09; commit_addr2 = 32'hBEEF;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, EENTRY, 1'b1, PC2, 7'h09,
                           32'hBEEF, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL excp_only_slot1 act=%h exp=%h", act, want); end
        clear_in();
        tick();
    endtask

    task automatic test_interrupt();
        bundle(2'b11, 2'b11); int_pending = 1'b1; crmd_ie = 1'b0;
        exp_q.push_back(pass(2'b11, 2'b00, 2'b00));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL int_masked act=%h exp=%h", act, want); end
        bundle(2'b11, 2'b11); int_pending = 1'b1; crmd_ie = 1'b1;
        excp_valid = 2'b01; excp_cause1 = 7'h0C; commit_addr1 = 32'h77;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, EENTRY, 1'b1, PC1, ICAUSE,
                           32'd0, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL int_taken act=%h exp=%h", act, want); end
        bundle(2'b11, 2'b11); int_pending = 1'b1; crmd_ie = 1'b1;
        exp_q.push_back('0);
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL int_flushwait act=%h exp=%h", act, want); end
        bundle(2'b10, 2'b10); int_pending = 1'b1; crmd_ie = 1'b1;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, EENTRY, 1'b1, PC2, ICAUSE,
                           32'd0, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL int_slot1 act=%h exp=%h", act, want); end
        clear_in();
        tick();
    endtask

    task automatic test_pause();
        bundle(2'b11, 2'b11); excp_valid = 2'b01; excp_cause1 = 7'h08; pause_mem = 1'b1;
        exp_q.push_back('0);
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL pause_bubble act=%h exp=%h", act, want); end
        pause_mem = 1'b0;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, EENTRY, 1'b1, PC1, 7'h08,
                           32'd0, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL pause_release act=%h exp=%h", act, want); end
        clear_in();
        tick();
    endtask

    task automatic test_ertn();
        bundle(2'b11, 2'b11); commit_ertn = 2'b01; csr_era = 32'h1C00_0200;
        exp_q.push_back(pk(2'b01, 2'b00, 2'b00, 1'b1, 32'h1C00_0200, 1'b0, 32'd0,
                           7'd0, 32'd0, 1'b1, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL ertn act=%h exp=%h", act, want); end
        bundle(2'b11, 2'b11);
        exp_q.push_back('0);
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL ertn_pulse act=%h exp=%h", act, want); end
    endtask

    task automatic test_idle();
        bundle(2'b11, 2'b11); commit_pc1 = 32'h1C00_0100; commit_idle = 2'b01;
        exp_q.push_back(pk(2'b01, 2'b00, 2'b00, 1'b1, 32'h1C00_0104, 1'b0, 32'd0,
                           7'd0, 32'd0, 1'b0, 1'b1));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL idle_enter act=%h exp=%h", act, want); end
        for (int i = 0; i < 10; i++) begin
            bundle(2'b11, 2'b11); int_pending = (i == 4); crmd_ie = 1'b0;
            exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0,
                               7'd0, 32'd0, 1'b0, 1'b1));
            tick(); want = exp_q.pop_front(); n_checks++;
            if (act !== want) begin n_fail++; $display("FAIL idle_hold act=%h exp=%h", act, want); end
        end
        clear_in(); int_pending = 1'b1; crmd_ie = 1'b1; pause_mem = 1'b1;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, EENTRY, 1'b1, 32'h1C00_0104,
                           ICAUSE, 32'd0, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL idle_wake act=%h exp=%h", act, want); end
        bundle(2'b11, 2'b11);
        exp_q.push_back('0);
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL idle_flushwait act=%h exp=%h", act, want); end
        bundle(2'b01, 2'b01);
        exp_q.push_back(pass(2'b01, 2'b00, 2'b00));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL idle_resume act=%h exp=%h", act, want); end
    endtask

    task automatic test_wrap();
        bundle(2'b11, 2'b11); commit_pc2 = 32'hFFFF_FFFC; commit_idle = 2'b10;
        exp_q.push_back(pk(2'b11, 2'b00, 2'b00, 1'b1, 32'd0, 1'b0, 32'd0,
                           7'd0, 32'd0, 1'b0, 1'b1));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL wrap_idle act=%h exp=%h", act, want); end
        clear_in(); int_pending = 1'b1; crmd_ie = 1'b1;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, EENTRY, 1'b1, 32'd0,
                           ICAUSE, 32'd0, 1'b0, 1'b0));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL wrap_era act=%h exp=%h", act, want); end
        clear_in();
        tick();
    endtask

    task automatic test_reset_in_idle();
        bundle(2'b01, 2'b00); commit_pc1 = 32'h1C00_0300; commit_idle = 2'b01;
        exp_q.push_back(pk(2'b00, 2'b00, 2'b00, 1'b1, 32'h1C00_0304, 1'b0, 32'd0,
                           7'd0, 32'd0, 1'b0, 1'b1));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL rst_idle_enter act=%h exp=%h", act, want); end
        bundle(2'b11, 2'b11); rst = 1'b1;
        exp_q.push_back('0);
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL rst_in_idle act=%h exp=%h", act, want); end
        rst = 1'b0;
        bundle(2'b11, 2'b11);
        exp_q.push_back(pass(2'b11, 2'b00, 2'b00));
        tick(); want = exp_q.pop_front(); n_checks++;
        if (act !== want) begin n_fail++; $display("FAIL rst_to_run act=%h exp=%h", act, want); end
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        test_reset();
        test_pass_through();
        test_excp_slot0();
        test_excp_slot1();
        test_interrupt();
        test_pause();
        test_ertn();
        test_idle();
        test_wrap();
        test_reset_in_idle();
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain act=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
